// File: rtl/laser_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : laser_tx_framer                                              |
// | Description : Pops bytes from the LaserDrop byte queue and serialises each |
// |               one onto the laser diode as an idle-high asynchronous frame: |
// |               start bit (0), 8 data bits LSB first, optional even parity,  |
// |               stop bit (1). Each bit lasts CLKS_PER_BIT clocks. Frames run |
// |               back to back with no idle gap while the queue has data.      |
// |                                                                            |
// | Parameters  : CLKS_PER_BIT  clocks per bit period (>= 2)                   |
// | Macro       : LASER_TX_PARITY_EN  inserts an even-parity bit after DATA    |
// |                                                                            |
// | Ports       : clock       system clock                                     |
// |               reset       asynchronous, active-high reset                  |
// |               clear       synchronous abort to idle, zeroes bytes_sent     |
// |               enable      permits new bytes to be popped                   |
// |               q_data      queue head byte, valid while q_empty = 0         |
// |               q_empty     queue empty flag                                 |
// |               q_read      one-cycle pop strobe (combinational)             |
// |               laser_out   registered serial line, 1 = idle/mark            |
// |               busy        a frame is in progress                           |
// |               byte_done   pulse in the final cycle of each stop bit        |
// |               bytes_sent  completed frames, wraps modulo 2^16              |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module laser_tx_framer #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   input  logic [7:0]  q_data,
   input  logic        q_empty,
   output logic        q_read,
   output logic        laser_out,
   output logic        busy,
   output logic        byte_done,
   output logic [15:0] bytes_sent
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] c_last = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef LASER_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t          r_state;
   logic [TW-1:0]   r_timer;
   logic [2:0]      r_index;
   logic [7:0]      r_shift;
   logic            r_laser;
   logic [15:0]     r_count;
`ifdef LASER_TX_PARITY_EN
   logic            r_parity;
`endif

   logic            w_last;
   logic            w_pop_ok;

   assign w_last   = (r_timer == c_last);
   assign w_pop_ok = enable & ~q_empty & ~clear;

   // The pop strobe is combinational so a byte is taken in the very cycle it
   // becomes available (idle) or in the last stop cycle (back-to-back).
   assign q_read = ~reset & w_pop_ok &
                   ((r_state == S_IDLE) | ((r_state == S_STOP) & w_last));

   assign byte_done  = (r_state == S_STOP) & w_last & ~clear;
   assign busy       = (r_state != S_IDLE);
   assign laser_out  = r_laser;
   assign bytes_sent = r_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_index <= 3'd0;
         r_shift <= 8'h00;
         r_laser <= 1'b1;
         r_count <= 16'd0;
`ifdef LASER_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else if (clear) begin
         // Abort: the partially sent byte is dropped.
         r_state <= S_IDLE;
         r_timer <= '0;
         r_index <= 3'd0;
         r_laser <= 1'b1;
         r_count <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (q_read) begin
                  r_shift <= q_data;
`ifdef LASER_TX_PARITY_EN
                  r_parity <= ^q_data;
`endif
                  r_state <= S_START;
                  r_timer <= '0;
                  r_laser <= 1'b0;
               end
            end

            S_START: begin
               if (w_last) begin
                  r_state <= S_DATA;
                  r_timer <= '0;
                  r_index <= 3'd0;
                  r_laser <= r_shift[0];
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

            S_DATA: begin
               if (w_last) begin
                  r_timer <= '0;
                  if (r_index == 3'd7) begin
`ifdef LASER_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_laser <= r_parity;
`else
                     r_state <= S_STOP;
                     r_laser <= 1'b1;
`endif
                  end else begin
                     // Next bit is shift[1]; shift so it lands in bit 0.
                     r_index <= r_index + 3'd1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_laser <= r_shift[1];
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

`ifdef LASER_TX_PARITY_EN
            S_PARITY: begin
               if (w_last) begin
                  r_state <= S_STOP;
                  r_timer <= '0;
                  r_laser <= 1'b1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
`endif

            S_STOP: begin
               if (w_last) begin
                  r_count <= r_count + 16'd1;
                  r_timer <= '0;
                  if (q_read) begin
                     // Chain straight into the next frame, no idle cycle.
                     r_shift <= q_data;
`ifdef LASER_TX_PARITY_EN
                     r_parity <= ^q_data;
`endif
                     r_state <= S_START;
                     r_laser <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                     r_laser <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_timer <= '0;
               r_laser <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_laser_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_laser_tx_framer                                           |
// | Description : Bench for laser_tx_framer with CLKS_PER_BIT = 4. A queue     |
// |               model feeds the DUT; bytes expected on the line are pushed   |
// |               to a scoreboard when loaded, and a serial decoder pops and   |
// |               compares them as frames complete. Pop strobes predict the    |
// |               byte_done cycle, which is checked when the pulse appears.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_laser_tx_framer;

   localparam int CPB = 4;
`ifdef LASER_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME_CYC = NB * CPB;

   logic        clock = 1'b0;
   logic        reset;
   logic        clear;
   logic        enable;
   logic [7:0]  q_data;
   logic        q_empty;
   logic        q_read;
   logic        laser_out;
   logic        busy;
   logic        byte_done;
   logic [15:0] bytes_sent;

   laser_tx_framer #(.CLKS_PER_BIT(CPB)) dut (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .enable     (enable),
      .q_data     (q_data),
      .q_empty    (q_empty),
      .q_read     (q_read),
      .laser_out  (laser_out),
      .busy       (busy),
      .byte_done  (byte_done),
      .bytes_sent (bytes_sent)
   );

   always #5 clock = ~clock;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          n_pops = 0;
   int          n_done = 0;
   logic [7:0]  fifo[$];
   logic [7:0]  exp_q[$];
   int          done_q[$];
   int          pop_cyc[$];
   logic        pop_pending = 1'b0;
   logic [15:0] mdl_count = 16'd0;
   logic        cnt_chk_pending = 1'b0;
   int          rx_phase = -1;
   logic [7:0]  rx_byte = 8'h00;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic fifo_upd();
      q_empty = (fifo.size() == 0);
      q_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
   endtask

   task automatic load(input logic [7:0] b, input bit expect_tx);
      fifo.push_back(b);
      if (expect_tx) exp_q.push_back(b);
      fifo_upd();
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_busy(input logic val, input int max);
      for (int i = 0; i < max; i++) begin
         if (busy === val) return;
         step();
      end
      chk("timeout_busy", busy, val);
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Queue model: the head is consumed just after the edge that took it.
   always @(posedge clock) begin
      if (pop_pending) begin
         #1;
         if (fifo.size() != 0) void'(fifo.pop_front());
         fifo_upd();
      end
   end

   always @(negedge clock) begin
      if (cnt_chk_pending) begin
         chk("bytes_sent_inc", bytes_sent, mdl_count);
         cnt_chk_pending = 1'b0;
      end
      if (reset || clear) begin
         rx_phase    = -1;
         pop_pending = 1'b0;
         mdl_count   = 16'd0;
         done_q.delete();
      end else begin
         pop_pending = q_read;
         if (q_read) begin
            chk("q_read_nonempty", q_empty, 1'b0);
            done_q.push_back(cyc + FRAME_CYC);
            pop_cyc.push_back(cyc);
            n_pops++;
         end
         if (byte_done) begin
            n_done++;
            if (done_q.size() == 0) chk("byte_done_unexpected", 1, 0);
            else chk("byte_done_cycle", cyc, done_q.pop_front());
            mdl_count       = mdl_count + 16'd1;
            cnt_chk_pending = 1'b1;
         end
         // Serial decoder, sampling each bit in its middle.
         if (rx_phase < 0) begin
            if (laser_out == 1'b0) begin
               rx_phase = 0;
               rx_byte  = 8'h00;
            end
         end else begin
            rx_phase++;
            if (rx_phase % CPB == CPB / 2) begin
               int idx;
               idx = rx_phase / CPB;
               if (idx == 0) begin
                  chk("start_bit", laser_out, 1'b0);
               end else if (idx >= 1 && idx <= 8) begin
                  rx_byte[idx-1] = laser_out;
`ifdef LASER_TX_PARITY_EN
               end else if (idx == 9) begin
                  if (exp_q.size() != 0) chk("parity_bit", laser_out, ^exp_q[0]);
`endif
               end else if (idx == NB - 1) begin
                  chk("stop_bit", laser_out, 1'b1);
                  if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
                  else chk("rx_byte", rx_byte, exp_q.pop_front());
               end
            end
            if (rx_phase == FRAME_CYC - 1) rx_phase = -1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p0, d0, k0;
      reset  = 1'b1;
      clear  = 1'b0;
      enable = 1'b0;
      fifo_upd();
      repeat (3) step();

      // Reset state, with a byte waiting and enable high: no pop allowed.
      load(8'h5A, 1'b0);
      enable = 1'b1;
      @(negedge clock);
      chk("rst_laser", laser_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_byte_done", byte_done, 1'b0);
      chk("rst_bytes_sent", bytes_sent, 16'd0);
      chk("rst_q_read", q_read, 1'b0);
      step();
      enable = 1'b0;
      fifo.delete();
      fifo_upd();
      reset = 1'b0;
      step();

      // Single byte 0xA5.
      p0 = n_pops;
      load(8'hA5, 1'b1);
      enable = 1'b1;
      wait_busy(1'b1, 10);
      wait_busy(1'b0, 3 * FRAME_CYC);
      chk("a5_pops", n_pops - p0, 1);
      chk("a5_bytes_sent", bytes_sent, 16'd1);
      enable = 1'b0;

      // Clear while idle zeroes the count.
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear_idle_count", bytes_sent, 16'd0);

      // Three bytes back to back.
      k0 = pop_cyc.size();
      load(8'h01, 1'b1);
      load(8'h02, 1'b1);
      load(8'h03, 1'b1);
      enable = 1'b1;
      wait_busy(1'b1, 10);
      wait_busy(1'b0, 5 * FRAME_CYC);
      chk("b2b_bytes_sent", bytes_sent, 16'd3);
      chk("b2b_pops", pop_cyc.size() - k0, 3);
      if (pop_cyc.size() - k0 == 3) begin
         chk("b2b_gap1", pop_cyc[k0+1] - pop_cyc[k0], FRAME_CYC);
         chk("b2b_gap2", pop_cyc[k0+2] - pop_cyc[k0+1], FRAME_CYC);
      end
      repeat (10) step();
      chk("b2b_idle_laser", laser_out, 1'b1);

      // Stream including the parity reference bytes and random data.
      load(8'h07, 1'b1);
      load(8'h03, 1'b1);
      load(8'($urandom_range(0, 255)), 1'b1);
      load(8'($urandom_range(0, 255)), 1'b1);
      wait_busy(1'b1, 10);
      wait_busy(1'b0, 6 * FRAME_CYC);
      chk("stream_bytes_sent", bytes_sent, 16'd7);
      enable = 1'b0;
      step();

      // Enable dropped during data bit 2 with another byte queued.
      p0 = n_pops;
      load(8'h3C, 1'b1);
      load(8'h99, 1'b0);
      enable = 1'b1;
      wait_busy(1'b1, 10);
      repeat (13) step();
      enable = 1'b0;
      wait_busy(1'b0, 2 * FRAME_CYC);
      chk("en_drop_bytes_sent", bytes_sent, 16'd8);
      repeat (50) step();
      chk("en_drop_pops", n_pops - p0, 1);
      chk("en_drop_busy", busy, 1'b0);
      chk("en_drop_laser", laser_out, 1'b1);
      fifo.delete();
      fifo_upd();

      // Clear during data bit 3 of 0xFF.
      p0 = n_pops;
      load(8'hFF, 1'b0);
      enable = 1'b1;
      wait_busy(1'b1, 10);
      enable = 1'b0;
      repeat (17) step();
      d0 = n_done;
      clear = 1'b1;
      step();
      clear = 1'b0;
      @(negedge clock);
      chk("clear_laser", laser_out, 1'b1);
      chk("clear_busy", busy, 1'b0);
      chk("clear_bytes_sent", bytes_sent, 16'd0);
      load(8'h55, 1'b0);
      repeat (60) step();
      chk("clear_no_done", n_done - d0, 0);
      chk("clear_pops", n_pops - p0, 1);
      chk("clear_still_idle", busy, 1'b0);
      fifo.delete();
      fifo_upd();

      // Reset during the second of two back-to-back frames (data bit 2 of 0xC3).
      load(8'h11, 1'b1);
      load(8'hC3, 1'b0);
      load(8'h5A, 1'b0);
      enable = 1'b1;
      wait_busy(1'b1, 10);
      repeat (FRAME_CYC + 12) step();
      chk("pre_rst_laser", laser_out, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_laser", laser_out, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_bytes_sent", bytes_sent, 16'd0);
      chk("mid_rst_q_read", q_read, 1'b0);
      step();
      enable = 1'b0;
      fifo.delete();
      fifo_upd();
      reset = 1'b0;
      repeat (5) step();

      chk("sb_rx_empty", exp_q.size(), 0);
      chk("sb_done_empty", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
